// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [2:0] TXDATA_OFS = 3'd0;
    localparam logic [2:0] STATUS_OFS = 3'd4;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    function automatic logic [31:0] pack_status(
        input logic       busy,
        input logic       full,
        input logic       empty,
        input logic       ovf,
        input logic [7:0] cnt
    );
        logic [31:0] s;
        s = '0;
        s[STAT_BUSY]           = busy;
        s[STAT_FULL]           = full;
        s[STAT_EMPTY]          = empty;
        s[STAT_OVF]            = ovf;
        s[STAT_CNT_LSB +: 8]   = cnt;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push and pop in the same cycle both take effect.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window, TX FIFO and serialiser FSM.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic        tx
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t     state;
    tx_state_t     state_next;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_next;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          tx_next;
    logic          baud_done;

    logic          sel_txdata;
    logic          sel_status;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          drop;
    logic          ovf;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [7:0]    head;
    logic          busy;
    logic          unused_bits;

    assign unused_bits = ^{Mem_WrData[31:8], Mem_WrAddr[1:0]};

    assign hit        = (Mem_WrAddr[31:3] == BASE_ADDR[31:3]);
    assign sel_txdata = (Mem_WrAddr[2] == TXDATA_OFS[2]);
    assign sel_status = (Mem_WrAddr[2] == STATUS_OFS[2]);

    // A push into a full FIFO is only accepted if the serialiser frees a slot on the same edge.
    assign push_req = MemWrite & hit & sel_txdata;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (Mem_WrData[7:0]),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (MemWrite && hit && sel_status && Mem_WrData[STAT_OVF]) begin
            ovf <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        ReadData = 32'b0;
        if (hit && sel_status) begin
            ReadData = pack_status(busy, full, empty, ovf, 8'(count));
        end
    end

    assign baud_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            tx       <= tx_next;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_next;
    end

    // tx is registered from the current state, so the line trails the FSM by one cycle.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        pop        = 1'b0;
        tx_next    = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = head;
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                tx_next = shift[0];
                if (baud_done) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    bit_next   = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx against a frame-timeline reference model.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int C = 4;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] Mem_WrAddr = BASE + 32'd4;
    logic [31:0] Mem_WrData = 32'd0;
    logic [31:0] ReadData;
    logic        hit;
    logic        tx;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    // Reference model: each accepted byte becomes a frame with its write edge and first start-bit edge.
    int         f_w[$];
    int         f_s[$];
    logic [7:0] f_b[$];
    logic       m_ovf = 1'b0;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .Mem_WrAddr (Mem_WrAddr),
        .Mem_WrData (Mem_WrData),
        .ReadData   (ReadData),
        .hit        (hit),
        .tx         (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    function automatic void model_clear();
        f_w.delete();
        f_s.delete();
        f_b.delete();
        m_ovf = 1'b0;
    endfunction

    function automatic void model_write(logic [31:0] a, logic [31:0] d, int w);
        int occ;
        bit pop_now;
        int s;
        int e;
        if (a[31:3] != BASE[31:3]) return;
        if (a[2]) begin
            if (d[3]) m_ovf = 1'b0;
            return;
        end
        occ = 0;
        pop_now = 0;
        for (int i = 0; i < f_s.size(); i++) begin
            if (f_w[i] < w && f_s[i] - 1 >= w) occ++;
            if (f_s[i] - 1 == w) pop_now = 1;
        end
        if (occ >= D && !pop_now) begin
            m_ovf = 1'b1;
            return;
        end
        s = w + 2;
        if (f_s.size() > 0) begin
            e = f_s[f_s.size() - 1] + 10 * C - 1;
            if (e > w) s = e + 2;
        end
        f_w.push_back(w);
        f_s.push_back(s);
        f_b.push_back(d[7:0]);
    endfunction

    function automatic logic exp_tx(int c);
        int k;
        for (int i = 0; i < f_s.size(); i++) begin
            if (c >= f_s[i] && c < f_s[i] + 10 * C) begin
                k = (c - f_s[i]) / C;
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return f_b[i][k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status(int c);
        int cnt;
        logic busy;
        logic [31:0] r;
        cnt = 0;
        busy = 1'b0;
        for (int i = 0; i < f_s.size(); i++) begin
            if (f_w[i] <= c && f_s[i] - 1 > c) cnt++;
            if (c >= f_s[i] - 1 && c <= f_s[i] + 10 * C - 2) busy = 1'b1;
        end
        r = 32'd0;
        r[0] = busy;
        r[1] = (cnt == D);
        r[2] = (cnt == 0);
        r[3] = m_ovf;
        r[15:8] = 8'(cnt);
        return r;
    endfunction

    function automatic int drain_cycles();
        int n;
        if (f_s.size() == 0) return 2;
        n = f_s[f_s.size() - 1] + 10 * C + 2 - cyc;
        return (n < 2) ? 2 : n;
    endfunction

    // Caller is just after a falling edge; the write lands on the next rising edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        MemWrite   = 1'b1;
        Mem_WrAddr = a;
        Mem_WrData = d;
        @(negedge clk);
        MemWrite   = 1'b0;
        Mem_WrAddr = BASE + 32'd4;
        model_write(a, d, cyc);
    endtask

    task automatic watch(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== exp_tx(cyc)) begin
                errors++;
                $display("FAIL %s_tx cyc=%0d got=%b exp=%b", tag, cyc, tx, exp_tx(cyc));
            end
            checks++;
            if (ReadData !== exp_status(cyc)) begin
                errors++;
                $display("FAIL %s_status cyc=%0d got=%h exp=%h", tag, cyc, ReadData, exp_status(cyc));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx got=%b exp=1", tx);
        end
        checks++;
        if (ReadData !== 32'h0000_0004) begin
            errors++;
            $display("FAIL reset_status got=%h exp=00000004", ReadData);
        end
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || ReadData !== 32'h0000_0004) begin
                errors++;
                $display("FAIL idle cyc=%0d tx=%b status=%h exp tx=1 status=00000004", cyc, tx, ReadData);
            end
        end
        Mem_WrAddr = BASE + 32'd8;
        #1;
        checks++;
        if (hit !== 1'b0 || ReadData !== 32'd0) begin
            errors++;
            $display("FAIL miss_read hit=%b rd=%h exp hit=0 rd=0", hit, ReadData);
        end
        Mem_WrAddr = BASE;
        #1;
        checks++;
        if (hit !== 1'b1 || ReadData !== 32'd0) begin
            errors++;
            $display("FAIL txdata_read hit=%b rd=%h exp hit=1 rd=0", hit, ReadData);
        end
        Mem_WrAddr = BASE + 32'd4;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_write(BASE, 32'hFFFF_FF55);
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL single_pop_cycle got=%b exp=1", tx);
        end
        for (int k = 0; k < 10 * C; k++) begin
            @(negedge clk);
            checks++;
            if (tx !== logic'((k / C) % 2)) begin
                errors++;
                $display("FAIL single_bit k=%0d got=%b exp=%0d", k, tx, (k / C) % 2);
            end
        end
        watch(drain_cycles(), "single_tail");
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 5; i++) begin
            do_write(BASE | 32'($urandom_range(0, 3)), $urandom);
            watch($urandom_range(3, 50), "rand");
        end
        watch(drain_cycles(), "rand_drain");
    endtask

    task automatic test_back_to_back();
        int gaps;
        int first_s;
        int last_e;
        do_write(BASE, 32'h0000_0041);
        do_write(BASE, 32'h0000_0042);
        do_write(BASE, 32'h0000_0043);
        #1;
        checks++;
        if (ReadData[15:8] !== 8'd2) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=2", ReadData[15:8]);
        end
        first_s = f_s[f_s.size() - 3];
        last_e  = f_s[f_s.size() - 1] + 10 * C - 1;
        checks++;
        if (f_s[f_s.size() - 1] - f_s[f_s.size() - 2] != 10 * C + 1) begin
            errors++;
            $display("FAIL b2b_model_spacing got=%0d exp=%0d", f_s[f_s.size() - 1] - f_s[f_s.size() - 2], 10 * C + 1);
        end
        gaps = 0;
        for (int i = 0; i < 200 && cyc < last_e + 3; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== exp_tx(cyc)) begin
                errors++;
                $display("FAIL b2b_tx cyc=%0d got=%b exp=%b", cyc, tx, exp_tx(cyc));
            end
            checks++;
            if (ReadData !== exp_status(cyc)) begin
                errors++;
                $display("FAIL b2b_status cyc=%0d got=%h exp=%h", cyc, ReadData, exp_status(cyc));
            end
            if (cyc >= first_s && cyc < last_e && ReadData[0] === 1'b0) gaps++;
        end
        checks++;
        if (gaps != 2) begin
            errors++;
            $display("FAIL b2b_busy_gaps got=%0d exp=2", gaps);
        end
    endtask

    task automatic test_overflow();
        int p;
        for (int i = 0; i < 10; i++) do_write(BASE, $urandom);
        #1;
        checks++;
        if (ReadData !== 32'h0000_080B) begin
            errors++;
            $display("FAIL ovf_status got=%h exp=0000080b", ReadData);
        end
        checks++;
        if (ReadData !== exp_status(cyc)) begin
            errors++;
            $display("FAIL ovf_model got=%h exp=%h", ReadData, exp_status(cyc));
        end
        do_write(BASE + 32'd4, 32'h0000_0008);
        #1;
        checks++;
        if (ReadData !== 32'h0000_0803) begin
            errors++;
            $display("FAIL ovf_clear got=%h exp=00000803", ReadData);
        end
        p = 0;
        for (int i = 0; i < f_s.size(); i++) begin
            if (p == 0 && f_s[i] - 1 > cyc) p = f_s[i] - 1;
        end
        for (int i = 0; i < 200 && cyc < p - 1; i++) @(negedge clk);
        checks++;
        if (cyc != p - 1) begin
            errors++;
            $display("FAIL ovf_align got=%0d exp=%0d", cyc, p - 1);
        end
        do_write(BASE, {24'h0, 8'($urandom)});
        #1;
        checks++;
        if (ReadData !== 32'h0000_0803) begin
            errors++;
            $display("FAIL push_on_pop got=%h exp=00000803", ReadData);
        end
        watch(drain_cycles(), "ovf_drain");
    endtask

    task automatic test_reset_mid();
        int target;
        do_write(BASE, {24'h0, 8'($urandom)});
        target = f_s[f_s.size() - 1] + 4 * C;
        for (int i = 0; i < 100 && cyc < target; i++) @(negedge clk);
        checks++;
        if (tx !== exp_tx(cyc)) begin
            errors++;
            $display("FAIL mid_pre_tx got=%b exp=%b", tx, exp_tx(cyc));
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_tx got=%b exp=1", tx);
        end
        checks++;
        if (ReadData !== 32'h0000_0004) begin
            errors++;
            $display("FAIL mid_reset_status got=%h exp=00000004", ReadData);
        end
        reset = 1'b0;
        model_clear();
        watch(60, "post_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_random_frames();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
